// File: rtl/reg_pipe.sv
// reg_pipe: WIDTH-bit, DEPTH-stage register pipeline with valid/ready on both
// ends and bubble collapsing. Stage 0 is the input end; the last stage drives
// Q/Q_Valid directly from flops, so there is no combinational path from D to Q.
//
// Optional feature: define REG_PIPE_FLUSH_EN to add a Flush input. A Flush
// edge clears every valid bit and the occupancy count but leaves the data
// registers untouched. Reset has priority over Flush.
//
// Handshake semantics (both ends): a word moves across an interface on a
// rising CLK edge where valid and ready are both 1. A producer holding valid
// keeps its data stable until that edge. Q_Valid, once set, stays set with Q
// unchanged until the output transfer. D_Ready may depend combinationally on
// Q_Ready, but it never depends on D_Valid.
module reg_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic                       CLK,
  input  logic                       Reset,
`ifdef REG_PIPE_FLUSH_EN
  input  logic                       Flush,
`endif
  input  logic [WIDTH-1:0]           D,
  input  logic                       D_Valid,
  output logic                       D_Ready,
  output logic [WIDTH-1:0]           Q,
  output logic                       Q_Valid,
  input  logic                       Q_Ready,
  output logic [$clog2(DEPTH+1)-1:0] Count
);

  localparam int unsigned     CW       = $clog2(DEPTH + 1);
  localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_adv;
  logic             w_flush;
  logic             w_in_xfer;
  logic             w_out_xfer;

`ifdef REG_PIPE_FLUSH_EN
  assign w_flush = Flush;
`else
  assign w_flush = 1'b0;
`endif

  // Advance terms: a stage can move forward if the stage ahead is empty or is
  // itself moving. Evaluated from the output end back toward the input.
  always_comb begin
    w_adv = '0;
    w_adv[DEPTH-1] = r_v[DEPTH-1] & Q_Ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      w_adv[i] = r_v[i] & (~r_v[i+1] | w_adv[i+1]);
    end
  end

  assign D_Ready    = ~Reset & ~w_flush & (~r_v[0] | w_adv[0]);
  assign w_in_xfer  = D_Valid & D_Ready;
  assign w_out_xfer = r_v[DEPTH-1] & Q_Ready;

  // Data registers: load only when a word moves into the stage, so a stalled
  // stage keeps its value. Flush leaves the data alone.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= RST_DATA;
      end
    end else if (!w_flush) begin
      if (w_in_xfer) begin
        r_data[0] <= D;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_adv[i-1]) begin
          r_data[i] <= r_data[i-1];
        end
      end
    end
  end

  // Valid bits: set when a word arrives, clear when the stage's word leaves
  // without a replacement, otherwise hold.
  always_ff @(posedge CLK) begin
    if (Reset || w_flush) begin
      r_v <= '0;
    end else begin
      if (w_in_xfer) begin
        r_v[0] <= 1'b1;
      end else if (w_adv[0]) begin
        r_v[0] <= 1'b0;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_adv[i-1]) begin
          r_v[i] <= 1'b1;
        end else if (w_adv[i]) begin
          r_v[i] <= 1'b0;
        end
      end
    end
  end

  // Occupancy: up on input-only, down on output-only, unchanged otherwise.
  always_ff @(posedge CLK) begin
    if (Reset || w_flush) begin
      r_count <= '0;
    end else begin
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign Q       = r_data[DEPTH-1];
  assign Q_Valid = r_v[DEPTH-1];
  assign Count   = r_count;

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed and random stimulus for reg_pipe (WIDTH=8, DEPTH=3,
// RESET_VAL=0). The driver pushes accepted words into exp_q; an independent
// monitor pops on every output transfer and checks data, hold stability and
// occupancy. Flush tests are built when REG_PIPE_FLUSH_EN is defined.
module tb_reg_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             CLK = 1'b0;
  logic             Reset;
  logic             Flush;
  logic [WIDTH-1:0] D;
  logic             D_Valid;
  logic             D_Ready;
  logic [WIDTH-1:0] Q;
  logic             Q_Valid;
  logic             Q_Ready;
  logic [1:0]       Count;

  logic [WIDTH-1:0] exp_q[$];
  int               n_cmp = 0;
  int               n_err = 0;
  logic             mon_en = 1'b0;
  logic             prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_q = '0;

  reg_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(0)) dut (
    .CLK     (CLK),
    .Reset   (Reset),
`ifdef REG_PIPE_FLUSH_EN
    .Flush   (Flush),
`endif
    .D       (D),
    .D_Valid (D_Valid),
    .D_Ready (D_Ready),
    .Q       (Q),
    .Q_Valid (Q_Valid),
    .Q_Ready (Q_Ready),
    .Count   (Count)
  );

  // Clock
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. exp_rdy / exp_qv of -1 mean "not checked".
  task automatic step(input logic dv, input logic [WIDTH-1:0] d, input logic qr,
                      input logic fl, input int exp_rdy, input int exp_qv);
    @(negedge CLK);
    D_Valid = dv;
    D       = d;
    Q_Ready = qr;
    Flush   = fl;
    #2;
    if (exp_rdy >= 0) check("d_ready", {31'd0, D_Ready}, exp_rdy);
    if (exp_qv >= 0)  check("q_valid", {31'd0, Q_Valid}, exp_qv);
    if (D_Valid && D_Ready) exp_q.push_back(D);
    @(posedge CLK);
    if (fl) exp_q.delete();
  endtask

  // Monitor: occupancy at +1, output transfer and hold stability at +3.
  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        #1;
        check("count", {30'd0, Count}, exp_q.size());
        #2;
        if (prev_hold) begin
          check("hold_valid", {31'd0, Q_Valid}, 32'd1);
          check("hold_data", {24'd0, Q}, {24'd0, prev_q});
        end
        if (Q_Valid && Q_Ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out: got %0h expected no output at %0t", Q, $time);
          end else begin
            e = exp_q.pop_front();
            check("q_data", {24'd0, Q}, {24'd0, e});
          end
        end
        prev_hold = Q_Valid & ~Q_Ready & ~Flush;
        prev_q    = Q;
      end
    end
  end

  initial begin
    // Reset with a valid word offered: it must not be captured.
    Reset = 1'b1; Flush = 1'b0; D_Valid = 1'b1; D = 8'hA5; Q_Ready = 1'b1;
    @(negedge CLK); #2;
    check("rst_d_ready", {31'd0, D_Ready}, 32'd0);
    @(negedge CLK); #2;
    check("rst_d_ready2", {31'd0, D_Ready}, 32'd0);
    @(negedge CLK);
    Reset = 1'b0; D_Valid = 1'b0;
    #2;
    check("rst_q_valid", {31'd0, Q_Valid}, 32'd0);
    check("rst_q", {24'd0, Q}, 32'h00);
    check("rst_count", {30'd0, Count}, 32'd0);
    check("rst_d_ready_after", {31'd0, D_Ready}, 32'd1);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);

    // Single word latency: Q_Valid exactly on the third edge after acceptance.
    step(1'b1, 8'h11, 1'b1, 1'b0, 1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);

    // Back-to-back stream at full throughput.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1, (i >= 3) ? 1 : 0);
    for (int j = 0; j < 4; j++)  step(1'b0, 8'h00, 1'b1, 1'b0, -1, (j < 3) ? 1 : 0);

    // Fill with output stalled, then simultaneous accept and emit.
    step(1'b1, 8'hA0, 1'b0, 1'b0, 1, 0);
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1, 0);
    step(1'b1, 8'hA2, 1'b0, 1'b0, 1, 0);
    step(1'b1, 8'hA3, 1'b0, 1'b0, 0, 1);
    step(1'b1, 8'hA3, 1'b0, 1'b0, 0, 1);
    step(1'b1, 8'hA3, 1'b1, 1'b0, 1, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);

`ifdef REG_PIPE_FLUSH_EN
    // Fill three words, flush for one edge, then a fresh word at full latency.
    step(1'b1, 8'hB0, 1'b0, 1'b0, 1, 0);
    step(1'b1, 8'hB1, 1'b0, 1'b0, 1, 0);
    step(1'b1, 8'hB2, 1'b0, 1'b0, 1, 0);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 0, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1, 0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, -1, 0);
`endif

    // Random traffic on both handshakes.
    void'($urandom(32'd12345));
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b0, -1, -1);
    end
    for (int j = 0; j < 6; j++) step(1'b0, 8'h00, 1'b1, 1'b0, -1, -1);

    @(negedge CLK); #4;
    check("drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
